// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit CPU pipeline control logic.
//   pipe_state_t : states of the stall/flush controller (RUN, BR_WAIT, FLUSH)
//   OP_BRANCH_*  : opcodes the hazard unit treats as branches
//   NOP_INSTR    : instruction word placed in IF/ID when it is flushed
// -----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        FLUSH   = 2'd2
    } pipe_state_t;

    localparam logic [3:0]  OP_BRANCH_0 = 4'b0100;
    localparam logic [3:0]  OP_BRANCH_1 = 4'b0101;
    localparam logic [3:0]  OP_BRANCH_2 = 4'b0110;

    localparam logic [15:0] NOP_INSTR   = 16'h0000;

    function automatic logic is_branch_op(input logic [3:0] op);
        return (op == OP_BRANCH_0) || (op == OP_BRANCH_1) || (op == OP_BRANCH_2);
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl_if
// Bundles the fetch-side inputs, hazard/branch requests and the pipeline
// control outputs of pipe_stall_ctrl.
//   master : environment side (fetch, hazard unit, EX) - drives requests
//   slave  : pipe_stall_ctrl side - drives pc_write/idex_bubble/IF-ID outputs
// Optional macro PIPE_STALL_STATS_EN adds stall_cycles and flush_count.
// -----------------------------------------------------------------------------
interface pipe_stall_ctrl_if #(
    parameter int SIZE = 16
);
    logic [SIZE-1:0] if_instr;
    logic [SIZE-1:0] if_pc;
    logic            if_valid;
    logic            load_use_stall;
    logic            branch_stall;
    logic            branch_resolved;
    logic            branch_taken;
    logic            pc_write;
    logic            idex_bubble;
    logic [SIZE-1:0] id_instr;
    logic [SIZE-1:0] id_pc;
    logic            id_valid;
    logic            err_timeout;
`ifdef PIPE_STALL_STATS_EN
    logic [SIZE-1:0] stall_cycles;
    logic [SIZE-1:0] flush_count;
`endif

    modport master (
        output if_instr, if_pc, if_valid,
        output load_use_stall, branch_stall, branch_resolved, branch_taken,
        input  pc_write, idex_bubble, id_instr, id_pc, id_valid, err_timeout
`ifdef PIPE_STALL_STATS_EN
        , input stall_cycles, flush_count
`endif
    );

    modport slave (
        input  if_instr, if_pc, if_valid,
        input  load_use_stall, branch_stall, branch_resolved, branch_taken,
        output pc_write, idex_bubble, id_instr, id_pc, id_valid, err_timeout
`ifdef PIPE_STALL_STATS_EN
        , output stall_cycles, flush_count
`endif
    );

endinterface

// File: rtl/pipe_stall_ctrl_ifid_reg.sv
// -----------------------------------------------------------------------------
// ifid_reg
// IF/ID pipeline register: instruction, PC and valid bit.
//   clk, rst          : clock, synchronous active-high reset (clears all)
//   i_we              : load i_instr/i_pc/i_valid
//   i_flush           : load a NOP bubble (instr=NOP, pc=0, valid=0);
//                       takes precedence over i_we
//   i_instr/i_pc/i_valid : next contents from fetch
//   o_instr/o_pc/o_valid : current contents toward decode
// -----------------------------------------------------------------------------
module ifid_reg
    import cpu_pkg::*;
#(
    parameter int SIZE = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_we,
    input  logic            i_flush,
    input  logic [SIZE-1:0] i_instr,
    input  logic [SIZE-1:0] i_pc,
    input  logic            i_valid,
    output logic [SIZE-1:0] o_instr,
    output logic [SIZE-1:0] o_pc,
    output logic            o_valid
);

    logic [SIZE-1:0] r_instr;
    logic [SIZE-1:0] r_pc;
    logic            r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr <= '0;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_instr <= SIZE'(NOP_INSTR);
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (i_we) begin
            r_instr <= i_instr;
            r_pc    <= i_pc;
            r_valid <= i_valid;
        end
    end

    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_valid = r_valid;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
// Enacts hazard-unit stall requests and EX branch resolution: decides each
// cycle whether the PC advances, whether ID/EX gets a bubble and whether the
// IF/ID register loads, holds or is flushed.
//   clk, rst : clock (rising edge), synchronous active-high reset
//   bus      : pipe_stall_ctrl_if.slave
//              in : if_instr, if_pc, if_valid, load_use_stall, branch_stall,
//                   branch_resolved, branch_taken
//              out: pc_write, idex_bubble (combinational),
//                   id_instr, id_pc, id_valid, err_timeout (registered)
// Optional macro PIPE_STALL_STATS_EN adds saturating counters stall_cycles
// (cycles with pc_write=0 outside reset) and flush_count (FLUSH entries).
// -----------------------------------------------------------------------------
module pipe_stall_ctrl
    import cpu_pkg::*;
#(
    parameter int SIZE           = 16,
    parameter int BRANCH_TIMEOUT = 4
) (
    input logic               clk,
    input logic               rst,
    pipe_stall_ctrl_if.slave  bus
);

    localparam int CNT_W = (BRANCH_TIMEOUT > 1) ? $clog2(BRANCH_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BRANCH_TIMEOUT - 1);

    pipe_state_t     r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic            r_err_timeout;

    logic            w_pc_write;
    logic            w_idex_bubble;
    logic            w_ifid_we;
    logic            w_ifid_flush;

    // Control is a pure function of state and this cycle's requests so a
    // request holds the PC in the same cycle it is raised.
    always_comb begin
        w_pc_write    = 1'b0;
        w_idex_bubble = 1'b1;
        w_ifid_we     = 1'b0;
        w_ifid_flush  = 1'b0;
        if (!rst) begin
            case (r_state)
                RUN: begin
                    if (!bus.branch_stall && !bus.load_use_stall) begin
                        w_pc_write    = 1'b1;
                        w_idex_bubble = 1'b0;
                        w_ifid_we     = 1'b1;
                    end
                end
                FLUSH: begin
                    // PC takes the EX branch target while IF/ID is cleared.
                    w_pc_write   = 1'b1;
                    w_ifid_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (bus.branch_stall) begin
                        r_state    <= BR_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                BR_WAIT: begin
                    // A resolution arriving on the last allowed cycle still
                    // counts as in time.
                    if (bus.branch_resolved) begin
                        r_state <= bus.branch_taken ? FLUSH : RUN;
                    end else if (r_wait_cnt == CNT_LAST) begin
                        r_state       <= FLUSH;
                        r_err_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                FLUSH:   r_state <= RUN;
                default: r_state <= RUN;
            endcase
        end
    end

    ifid_reg #(
        .SIZE (SIZE)
    ) u_ifid_reg (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_ifid_we),
        .i_flush (w_ifid_flush),
        .i_instr (bus.if_instr),
        .i_pc    (bus.if_pc),
        .i_valid (bus.if_valid),
        .o_instr (bus.id_instr),
        .o_pc    (bus.id_pc),
        .o_valid (bus.id_valid)
    );

    assign bus.pc_write    = w_pc_write;
    assign bus.idex_bubble = w_idex_bubble;
    assign bus.err_timeout = r_err_timeout;

`ifdef PIPE_STALL_STATS_EN
    logic [SIZE-1:0] r_stall_cycles;
    logic [SIZE-1:0] r_flush_count;
    logic            w_flush_entry;

    function automatic logic [SIZE-1:0] sat_inc(input logic [SIZE-1:0] v);
        return (&v) ? v : v + SIZE'(1);
    endfunction

    // Mirrors the BR_WAIT exit conditions that lead into FLUSH.
    assign w_flush_entry = (r_state == BR_WAIT) &&
                           (bus.branch_resolved ? bus.branch_taken
                                                : (r_wait_cnt == CNT_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!w_pc_write) r_stall_cycles <= sat_inc(r_stall_cycles);
            if (w_flush_entry) r_flush_count <= sat_inc(r_flush_count);
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;
    localparam int SIZE = 16;
    localparam int BT   = 4;

    logic clk;
    logic rst;
    int   n_err;
    int   n_chk;

    pipe_stall_ctrl_if #(.SIZE(SIZE)) bus ();

    pipe_stall_ctrl #(.SIZE(SIZE), .BRANCH_TIMEOUT(BT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: tracks "waiting for a branch for N cycles" and
    // "a flush is due next cycle" as plain flags/counters.
    bit      m_waiting;
    int      m_waited;
    bit      m_flush_due;
    logic [15:0] m_instr, m_pc;
    logic    m_valid;
    logic    m_err;
    int      m_stalls;
    int      m_flushes;
    logic    e_pc, e_bub;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_waiting = 0; m_waited = 0; m_flush_due = 0;
        m_instr = '0; m_pc = '0; m_valid = 1'b0; m_err = 1'b0;
        m_stalls = 0; m_flushes = 0;
    endtask

    // One clock cycle: drive, check combinational outputs, clock, update
    // model, check registered outputs.
    task automatic cyc(input logic r, input logic [15:0] ins, input logic [15:0] pc,
                       input logic v, input logic lu, input logic bs,
                       input logic res, input logic tk);
        @(negedge clk);
        rst = r;
        bus.if_instr = ins; bus.if_pc = pc; bus.if_valid = v;
        bus.load_use_stall = lu; bus.branch_stall = bs;
        bus.branch_resolved = res; bus.branch_taken = tk;
        if (r)                  begin e_pc = 0; e_bub = 1; end
        else if (m_flush_due)   begin e_pc = 1; e_bub = 1; end
        else if (m_waiting)     begin e_pc = 0; e_bub = 1; end
        else if (bs || lu)      begin e_pc = 0; e_bub = 1; end
        else                    begin e_pc = 1; e_bub = 0; end
        #1;
        chk("pc_write", 32'(bus.pc_write), 32'(e_pc));
        chk("idex_bubble", 32'(bus.idex_bubble), 32'(e_bub));
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (!e_pc) m_stalls++;
            if (m_flush_due) begin
                m_instr = '0; m_pc = '0; m_valid = 1'b0; m_flush_due = 0;
            end else if (m_waiting) begin
                if (res) begin
                    m_waiting = 0;
                    if (tk) begin m_flush_due = 1; m_flushes++; end
                end else if (m_waited == BT - 1) begin
                    m_waiting = 0; m_flush_due = 1; m_err = 1'b1; m_flushes++;
                end else begin
                    m_waited++;
                end
            end else if (bs) begin
                m_waiting = 1; m_waited = 0;
            end else if (!lu) begin
                m_instr = ins; m_pc = pc; m_valid = v;
            end
        end
        #1;
        chk("id_instr", 32'(bus.id_instr), 32'(m_instr));
        chk("id_pc", 32'(bus.id_pc), 32'(m_pc));
        chk("id_valid", 32'(bus.id_valid), 32'(m_valid));
        chk("err_timeout", 32'(bus.err_timeout), 32'(m_err));
`ifdef PIPE_STALL_STATS_EN
        chk("stall_cycles", 32'(bus.stall_cycles), 32'(m_stalls));
        chk("flush_count", 32'(bus.flush_count), 32'(m_flushes));
`endif
    endtask

    task automatic idle(input logic [15:0] pc);
        cyc(0, 16'h1000 | pc, pc, 1, 0, 0, 0, 0);
    endtask

    initial begin
        n_err = 0; n_chk = 0;
        rst = 1'b1;
        bus.if_instr = '0; bus.if_pc = '0; bus.if_valid = 1'b0;
        bus.load_use_stall = 0; bus.branch_stall = 0;
        bus.branch_resolved = 0; bus.branch_taken = 0;
        model_reset();

        // Reset, then first load
        cyc(1, 16'hAAAA, 16'h0055, 1, 0, 0, 0, 0);
        cyc(1, 16'hAAAA, 16'h0055, 1, 0, 0, 0, 0);
        chk("reset_id_pc", 32'(bus.id_pc), 32'h0);
        chk("reset_id_valid", 32'(bus.id_valid), 32'h0);
        idle(16'h0010);
        chk("first_load_pc", 32'(bus.id_pc), 32'h0010);

        // Load-use stall holds IF/ID for one cycle
        cyc(0, 16'h1022, 16'h0022, 1, 1, 0, 0, 0);
        chk("lu_hold_pc", 32'(bus.id_pc), 32'h0010);
        idle(16'h0022);
        chk("lu_then_load", 32'(bus.id_pc), 32'h0022);

        // Branch not taken, resolved two cycles after the request
        cyc(0, 16'h4030, 16'h0030, 1, 0, 1, 0, 0);
        idle(16'h0030);
        cyc(0, 16'h1030, 16'h0030, 1, 0, 0, 1, 0);
        chk("nt_valid_kept", 32'(bus.id_valid), 32'h1);
        idle(16'h0030);

        // Branch taken with both requests (branch wins), resolved next cycle
        cyc(0, 16'h5040, 16'h0040, 1, 1, 1, 0, 0);
        cyc(0, 16'h1040, 16'h0040, 1, 0, 0, 1, 1);
        cyc(0, 16'h1050, 16'h0050, 1, 0, 0, 0, 0);
        chk("taken_flush_valid", 32'(bus.id_valid), 32'h0);
        idle(16'h0050);

        // Timeout: no resolution for BT cycles
        cyc(0, 16'h6060, 16'h0060, 1, 0, 1, 0, 0);
        for (int i = 0; i < BT; i++) idle(16'h0060);
        chk("timeout_err", 32'(bus.err_timeout), 32'h1);
        idle(16'h0070);
        for (int i = 0; i < 3; i++) idle(16'h0070 + 16'(i));
        chk("err_sticky", 32'(bus.err_timeout), 32'h1);

        // Resolution on the final wait cycle beats timeout
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 16'h4080, 16'h0080, 1, 0, 1, 0, 0);
        for (int i = 0; i < BT - 1; i++) idle(16'h0080);
        cyc(0, 16'h1080, 16'h0080, 1, 0, 0, 1, 0);
        chk("res_beats_timeout", 32'(bus.err_timeout), 32'h0);

        // Reset in the middle of a branch wait
        cyc(0, 16'h4090, 16'h0090, 1, 0, 1, 0, 0);
        idle(16'h0090);
        cyc(1, 0, 0, 0, 0, 0, 1, 1);
        idle(16'h00A0);
        chk("post_rst_run", 32'(bus.id_pc), 32'h00A0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 79) == 0),
                16'($urandom), 16'($urandom), 1'($urandom),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 3) == 0), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Pipeline stall/flush responder for the 16-bit CPU: consumes the stall requests raised by the hazard detection unit plus branch resolution from EX, and enacts them. Owns the IF/ID pipeline register and drives PC write enable and ID/EX bubble insertion. Sits between fetch and decode; the hazard unit requests, this block decides cycle-by-cycle who holds, who bubbles, who flushes.

## Interface
- SIZE, 16, instruction/PC width
- BRANCH_TIMEOUT, 4, max BR_WAIT cycles before forced flush (≥2)

- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous, active-high
- if_instr  in  SIZE  instruction from fetch
- if_pc  in  SIZE  PC of if_instr
- if_valid  in  1  fetch output valid
- load_use_stall  in  1  hazard unit load-use request
- branch_stall  in  1  hazard unit: branch (opcode 0100/0101/0110) in ID
- branch_resolved  in  1  EX: branch outcome valid this cycle
- branch_taken  in  1  EX: outcome, qualified by branch_resolved
- pc_write  out  1  PC register write enable
- idex_bubble  out  1  force ID/EX control to NOP
- id_instr  out  SIZE  IF/ID instruction
- id_pc  out  SIZE  IF/ID PC
- id_valid  out  1  IF/ID valid
- err_timeout  out  1  sticky: branch never resolved within BRANCH_TIMEOUT

## Operation
- FSM states: RUN, BR_WAIT, FLUSH (2-bit). Reset → RUN.
- RUN:
  - branch_stall=1 (priority over load_use_stall): pc_write=0, IF/ID holds, idex_bubble=1, next BR_WAIT, wait counter←0.
  - else load_use_stall=1: pc_write=0, IF/ID holds, idex_bubble=1, stay RUN (single bubble per asserted cycle).
  - else: pc_write=1, IF/ID loads {if_instr, if_pc, if_valid}, idex_bubble=0.
  - branch_resolved ignored in RUN.
- BR_WAIT: pc_write=0, IF/ID holds, idex_bubble=1; load_use_stall/branch_stall ignored.
  - branch_resolved & branch_taken → FLUSH.
  - branch_resolved & !branch_taken → RUN.
  - counter = BRANCH_TIMEOUT-1 with no resolution → FLUSH, err_timeout←1.
  - else counter+1 (counter width $clog2(BRANCH_TIMEOUT), never wraps).
- FLUSH (exactly one cycle): pc_write=1 (PC takes EX target), IF/ID loads instr=0, pc=0, valid=0, idex_bubble=1; all requests ignored; next RUN.
- err_timeout cleared only by rst.

## Timing
- pc_write, idex_bubble: combinational from state and same-cycle inputs (zero latency to request).
- IF/ID and FSM update on rising clk edge.
- Reset values: id_instr=0, id_pc=0, id_valid=0, err_timeout=0, state=RUN, counter=0; during rst-high cycle pc_write=0, idex_bubble=1.
- rst mid-BR_WAIT or FLUSH: next cycle RUN, IF/ID cleared, no flush completion.
- branch_resolved in first BR_WAIT cycle (the cycle after entry) is honored.
- Resolution and timeout in same cycle: resolution wins, err_timeout not set.

## Configuration
- PIPE_STALL_STATS_EN defined: adds outputs stall_cycles (SIZE) counting cycles with pc_write=0 outside rst, and flush_count (SIZE) counting FLUSH entries; both saturate at all-ones, reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Shared package cpu_pkg: pipe_state_t enum (RUN, BR_WAIT, FLUSH), branch opcode constants 4'b0100/4'b0101/4'b0110, NOP instruction constant (0).
- One sub-module: ifid_reg (SIZE-wide instr/pc + valid, write-enable, flush, sync reset).

## Test plan
- Reset: rst=1 two cycles → id_valid=0, id_pc=0, err_timeout=0, pc_write=0; release, if_pc=0x0010 valid → next cycle id_pc=0x0010.
- Load-use: load_use_stall=1 one cycle with if_pc=0x0022 → pc_write=0, idex_bubble=1, id_pc unchanged; next cycle loads 0x0022.
- Branch not taken: branch_stall=1, resolved=1 taken=0 two cycles later → 3 cycles pc_write=0, then RUN, no valid drop.
- Branch taken: branch_stall=1, next cycle resolved=1 taken=1 → FLUSH cycle pc_write=1, id_valid=0 after edge, then RUN.
- Timeout: BRANCH_TIMEOUT=4, branch_stall, no resolve → FLUSH after 4 BR_WAIT cycles, err_timeout=1 until rst.
- Priority/stats: branch_stall & load_use_stall same cycle → BR_WAIT entered; with PIPE_STALL_STATS_EN, stall_cycles equals counted pc_write=0 cycles, flush_count=1 after taken branch.
